// File: rtl/tw_sched_if.sv
// Handshake bundle between a stage's control path and its twiddle scheduler.
// The master drives frame control and beats; the slave returns the ROM address, mode and aligned valid/phase.
interface tw_sched_if #(
  parameter int LOGN = 12
) ();
  logic            start;
  logic            intt;
  logic            in_valid;
  logic [LOGN-1:0] tw_raddr;
  logic            tw_intt;
  logic            tw_valid;
  logic            tw_phase;
  logic            busy;
  logic            done;

  modport master (
    output start, intt, in_valid,
    input  tw_raddr, tw_intt, tw_valid, tw_phase, busy, done
  );

  modport slave (
    input  start, intt, in_valid,
    output tw_raddr, tw_intt, tw_valid, tw_phase, busy, done
  );
endinterface

// File: rtl/tw_sched.sv
// Per-stage twiddle scheduler: turns a frame of streamed beats into twiddle ROM addresses
// plus a valid/phase pipeline aligned with the ROM wrapper's output.
module tw_sched #(
  parameter int LOGN       = 12,
  parameter int STAGE      = 0,
  parameter int DELAY_BROM = 2
) (
  input logic       clk,
  input logic       rst_n,
  tw_sched_if.slave bus
);
  localparam int LAT = DELAY_BROM + 1;
  localparam int DW  = $clog2(LAT + 1);
  localparam logic [LOGN-1:0] MASK = LOGN'((1 << STAGE) - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]      state;
  logic [LOGN-1:0] cnt;
  logic [LOGN-1:0] raddr;
  logic            mode;
  logic            done_r;
  logic [DW-1:0]   drain_cnt;
  logic            iss_v;
  logic            iss_p;
  logic [LAT-1:0]  pipe_v;
  logic [LAT-1:0]  pipe_p;
  logic            accept;

  assign accept = (state == RUN) && bus.in_valid;

  // The issue stage sits alongside tw_raddr; the LAT stages behind it track the wrapper latency.
  // Phase is masked at entry so it is already zero wherever valid is zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_v  <= 1'b0;
      iss_p  <= 1'b0;
      pipe_v <= '0;
      pipe_p <= '0;
    end else begin
      iss_v     <= accept;
      iss_p     <= accept & cnt[STAGE];
      pipe_v[0] <= iss_v;
      pipe_p[0] <= iss_p;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_p[i] <= pipe_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      raddr     <= '0;
      mode      <= 1'b0;
      done_r    <= 1'b0;
      drain_cnt <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode  <= bus.intt;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            raddr <= cnt & MASK;
            cnt   <= cnt + LOGN'(1);
            if (cnt == {LOGN{1'b1}}) begin
              state     <= DRAIN;
              drain_cnt <= DW'(LAT);
            end
          end
        end
        DRAIN: begin
          // done is registered one cycle early so it lands with the last issued bit at the output.
          if (drain_cnt == DW'(1)) done_r <= 1'b1;
          if (drain_cnt == '0) state <= IDLE;
          else drain_cnt <= drain_cnt - DW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tw_raddr = raddr;
  assign bus.tw_intt  = mode;
  assign bus.tw_valid = pipe_v[LAT-1];
  assign bus.tw_phase = pipe_p[LAT-1];
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
endmodule

// File: tb/tb_tw_sched.sv
// Directed bench for tw_sched: a LOGN=4/STAGE=2/LAT=3 instance for the main scenarios
// and a STAGE=0/LAT=1 instance for the degenerate-stage case.
module tb_tw_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  tw_sched_if #(.LOGN(4)) a_if ();
  tw_sched_if #(.LOGN(4)) b_if ();

  tw_sched #(.LOGN(4), .STAGE(2), .DELAY_BROM(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  tw_sched #(.LOGN(4), .STAGE(0), .DELAY_BROM(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view {raddr, intt, valid, phase, busy, done}.
  function automatic logic [8:0] obs_a();
    return {a_if.tw_raddr, a_if.tw_intt, a_if.tw_valid, a_if.tw_phase, a_if.busy, a_if.done};
  endfunction

  function automatic logic [8:0] obs_b();
    return {b_if.tw_raddr, b_if.tw_intt, b_if.tw_valid, b_if.tw_phase, b_if.busy, b_if.done};
  endfunction

  // One full 16-beat frame on dut_a; the start cycle is the current cycle, ends at s+21 (idle).
  task automatic run_frame(input string name, input logic mode, input logic toggle,
                           input logic noisy, input logic [3:0] raddr0);
    logic [8:0] exp;
    logic [3:0] ra;
    logic       v;
    logic       p;
    a_if.start    = 1'b1;
    a_if.intt     = mode;
    a_if.in_valid = noisy;
    vecs++;
    if ({a_if.tw_valid, a_if.tw_phase, a_if.busy, a_if.done} !== 4'b0000) begin
      errs++;
      $display("[TB] FAIL %s k=0 v/p/busy/done got %b expected 0000", name,
               {a_if.tw_valid, a_if.tw_phase, a_if.busy, a_if.done});
    end
    tick();
    for (int k = 1; k <= 20; k++) begin
      a_if.start    = noisy;
      a_if.in_valid = (k <= 16) || noisy;
      a_if.intt     = (toggle && (k % 2 == 1)) ? ~mode : mode;
      ra  = (k == 1) ? raddr0 : (k <= 17) ? 4'((k - 2) % 4) : 4'd3;
      v   = (k >= 5);
      p   = v && ((((k - 5) >> 2) & 1) == 1);
      exp = {ra, mode, v, p, 1'b1, (k == 20)};
      vecs++;
      if (obs_a() !== exp) begin
        errs++;
        $display("[TB] FAIL %s k=%0d got %b expected %b", name, k, obs_a(), exp);
      end
      tick();
    end
    a_if.start    = 1'b0;
    a_if.in_valid = 1'b0;
    a_if.intt     = 1'b0;
  endtask

  task automatic test_reset();
    a_if.start = 0; a_if.intt = 0; a_if.in_valid = 0;
    b_if.start = 0; b_if.intt = 0; b_if.in_valid = 0;
    rst_n = 1'b0;
    tick();
    tick();
    vecs++;
    if (obs_a() !== 9'b0) begin
      errs++;
      $display("[TB] FAIL reset_a got %b expected 0", obs_a());
    end
    vecs++;
    if (obs_b() !== 9'b0) begin
      errs++;
      $display("[TB] FAIL reset_b got %b expected 0", obs_b());
    end
    rst_n = 1'b1;
    tick();
    vecs++;
    if (obs_a() !== 9'b0) begin
      errs++;
      $display("[TB] FAIL post_reset_idle got %b expected 0", obs_a());
    end
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_first", 1'b0, 1'b0, 1'b0, 4'd0);
    run_frame("b2b_second", 1'b0, 1'b0, 1'b0, 4'd3);
  endtask

  task automatic test_gapped();
    logic [8:0] exp;
    logic [3:0] ra;
    logic       v;
    logic       p;
    int         j;
    a_if.start = 1'b1;
    a_if.intt  = 1'b0;
    tick();
    a_if.start = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      a_if.in_valid = (k <= 32) && (k % 2 == 1);
      j   = (k - 2) / 2;
      if (j > 15) j = 15;
      ra  = (k == 1) ? 4'd3 : 4'(j % 4);
      v   = (k >= 5) && (k <= 35) && (k % 2 == 1);
      p   = v && (((((k - 5) / 2) >> 2) & 1) == 1);
      exp = {ra, 1'b0, v, p, (k <= 35), (k == 35)};
      vecs++;
      if (obs_a() !== exp) begin
        errs++;
        $display("[TB] FAIL gapped k=%0d got %b expected %b", k, obs_a(), exp);
      end
      tick();
    end
    a_if.in_valid = 1'b0;
  endtask

  task automatic test_mode_latch();
    run_frame("intt_one", 1'b1, 1'b1, 1'b0, 4'd3);
    run_frame("intt_zero", 1'b0, 1'b1, 1'b0, 4'd3);
  endtask

  task automatic test_ignored_controls();
    a_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (obs_a() !== {4'd3, 5'b00000}) begin
        errs++;
        $display("[TB] FAIL idle_in_valid i=%0d got %b expected %b", i, obs_a(), {4'd3, 5'b00000});
      end
    end
    run_frame("noisy", 1'b1, 1'b0, 1'b1, 4'd3);
    run_frame("after_noisy", 1'b0, 1'b0, 1'b0, 4'd3);
  endtask

  task automatic test_reset_mid_frame();
    a_if.start = 1'b1;
    a_if.intt  = 1'b1;
    tick();
    a_if.start = 1'b0;
    a_if.intt  = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      a_if.in_valid = 1'b1;
      tick();
    end
    vecs++;
    if ({a_if.busy, a_if.tw_intt, a_if.tw_valid} !== 3'b111) begin
      errs++;
      $display("[TB] FAIL mid_frame busy/intt/valid got %b expected 111",
               {a_if.busy, a_if.tw_intt, a_if.tw_valid});
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (obs_a() !== 9'b0) begin
        errs++;
        $display("[TB] FAIL after_mid_reset i=%0d got %b expected 0", i, obs_a());
      end
      tick();
    end
    run_frame("post_reset_frame", 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_stage0();
    logic [8:0] exp;
    logic       v;
    logic       p;
    b_if.start = 1'b1;
    b_if.intt  = 1'b0;
    tick();
    b_if.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      b_if.in_valid = (k <= 16);
      v   = (k >= 3) && (k <= 18);
      p   = v && ((k - 3) % 2 == 1);
      exp = {4'd0, 1'b0, v, p, (k <= 18), (k == 18)};
      vecs++;
      if (obs_b() !== exp) begin
        errs++;
        $display("[TB] FAIL stage0 k=%0d got %b expected %b", k, obs_b(), exp);
      end
      tick();
    end
    b_if.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_mode_latch();
    test_ignored_controls();
    test_reset_mid_frame();
    test_stage0();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/tw_sched.md
# tw_sched

Per-stage twiddle scheduler for the SDF NTT/INTT pipeline. It sits in front of one stage's twiddle ROM wrapper and sequences a frame of N = 2^LOGN streamed coefficients. For each accepted beat it generates the stage-local twiddle read address, holds the NTT/INTT mode stable for the whole frame, and produces a valid/phase pipeline aligned to the wrapper's output. The butterfly uses that pipeline to know when `dout` carries a real twiddle.

## Interface
- `LOGN`, default 12: log2 of polynomial length N; width of the sample counter and `tw_raddr`.
- `STAGE`, default 0: NTT stage index, legal range 0..LOGN-1; sets the twiddle period 2^STAGE.
- `DELAY_BROM`, default 2: twiddle BROM read latency. Total ROM-wrapper latency is LAT = DELAY_BROM+1, because the wrapper adds an output register.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: frame start request; sampled only in IDLE.
- `intt`, input, 1: mode for the frame (1 = inverse); latched on the accepted `start`.
- `in_valid`, input, 1: one coefficient beat is entering the stage this cycle.
- `tw_raddr`, output, LOGN: registered read address for the twiddle ROM wrapper.
- `tw_intt`, output, 1: registered mode driven to the wrapper's `intt`.
- `tw_valid`, output, 1: the wrapper's `dout` is a valid twiddle this cycle.
- `tw_phase`, output, 1: butterfly-half flag aligned with `tw_valid`.
- `busy`, output, 1: asserted in RUN and DRAIN.
- `done`, output, 1: one-cycle pulse coinciding with the last `tw_valid` of the frame.

## Operation
- State machine has three states: IDLE, RUN, DRAIN.
- **IDLE:**
  - `start`=1: latch `tw_intt`<=`intt`, clear beat counter `cnt`<=0, go to RUN.
  - `in_valid` is ignored in IDLE, including in the same cycle as `start`.
- **RUN:** each cycle with `in_valid`=1 is an accepted beat.
  - `tw_raddr` <= `cnt` & (2^STAGE-1), zero-extended to LOGN bits. For STAGE=0 the address is always 0.
  - An issue bit (1) and phase bit `cnt[STAGE]` are pushed into a LAT-deep shift pipeline.
  - `cnt` increments.
  - Cycles with `in_valid`=0 push 0 into the pipeline and hold `cnt` and `tw_raddr`.
- **RUN exit:** when the accepted beat has `cnt`=N-1, `cnt` wraps to 0 and the state goes to DRAIN.
- **DRAIN:**
  - Pipeline keeps shifting zeros in.
  - `in_valid` and `start` are ignored.
  - A down-counter loaded with LAT counts to the last issued beat.
  - When the final issued bit reaches the pipeline output, `done`=1 for that cycle and the next state is IDLE.
- `tw_valid` and `tw_phase` are the pipeline's output stage. `tw_phase` is forced to 0 whenever `tw_valid`=0.
- `tw_intt` is constant from the accepted `start` until the cycle after `done`. It changes only on the next accepted `start`.
- **Width rules:** `cnt` is LOGN bits and wraps naturally. The DRAIN counter is sized for values up to LAT. No arithmetic is performed on twiddle data.
- **Reset:** `rst_n`=0 at any clock edge, including mid-frame or mid-DRAIN, forces:
  - state IDLE;
  - `cnt`=0, `tw_raddr`=0, `tw_intt`=0;
  - the whole pipeline cleared, so `tw_valid`=0 and `tw_phase`=0;
  - `busy`=0, `done`=0.
  - No partial-frame `done` is produced.

## Timing
- Beat accepted at cycle t: `tw_raddr` is valid at t+1, and `tw_valid`/`tw_phase` for that beat are at t+1+LAT.
- Throughput is one beat per cycle. Gaps in `in_valid` appear as identical gaps in `tw_valid`.
- `start` at cycle s: `busy`=1 from s+1. The first beat can be accepted at s+1.
- Last beat at cycle t_last:
  - `done`=1 and the last `tw_valid`=1 at t_last+1+LAT;
  - `busy`=0 at t_last+2+LAT;
  - a new `start` is accepted from that cycle.
- `start` in the `done` cycle is ignored, because the block is still in DRAIN.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Parameters for scenarios 1–4: LOGN=4, STAGE=2, DELAY_BROM=2, so LAT=3.

1. **Back-to-back frame:** `start`, then 16 contiguous beats.
   - `tw_raddr` = 0,1,2,3 repeated 4 times.
   - `tw_valid` high for cycles s+5..s+20; `tw_phase` = 0000 1111 0000 1111.
   - `done` at s+20; `busy` falls at s+21.
2. **Gapped input:** `in_valid` alternates 1/0 for 32 cycles.
   - `tw_valid` reproduces the alternating pattern delayed by 4.
   - `tw_raddr` holds during gaps; exactly one `done`.
3. **Mode latch:** `start` with `intt`=1, then toggle `intt` every cycle during the frame.
   - `tw_intt`=1 throughout the frame.
   - A second frame started with `intt`=0 gives `tw_intt`=0.
4. **Ignored controls:**
   - `start` asserted in RUN, in DRAIN and in the `done` cycle, plus `in_valid` asserted in IDLE and DRAIN: no state change, no extra `tw_valid`.
   - `start` at `busy`=0 is accepted.
5. **Reset mid-frame:** `rst_n`=0 for 1 cycle after 7 beats.
   - Next cycle: all outputs 0, state IDLE, no `done`.
   - A following full frame behaves exactly as scenario 1.
6. **STAGE=0, DELAY_BROM=0 (LAT=1):** 16 beats.
   - `tw_raddr` is always 0 and `tw_phase` follows `cnt[0]` (0,1,0,1…).
   - `done` comes 2 cycles after the last beat.
